// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared widths, producer latencies and source-hazard helper.
// Revision : 1.0  initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int LAT_W    = 3;
    localparam int MAX_LAT  = 7;

    // Cycles until a producer's result is visible to ID; the decoder drives id_lat_i from these.
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_SC   = 2;
    localparam int LAT_MUL  = 5;

    typedef struct packed {
        logic late;   // blocks any consumer
        logic early;  // blocks only an ID-resolved branch/jump-register
    } src_haz_t;

    function automatic src_haz_t classify_src(
        input logic used,
        input logic idx_nz,
        input logic cnt_gt1,
        input logic cnt_nz,
        input logic bj
    );
        src_haz_t h;
        h.late  = used && idx_nz && cnt_gt1;
        h.early = used && idx_nz && bj && cnt_nz;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID-stage request and interlock response bundle for the scoreboard.
// Revision : 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW   = hazard_scoreboard_pkg::REG_AW,
    parameter int NUM_REGS = hazard_scoreboard_pkg::NUM_REGS,
    parameter int LAT_W    = hazard_scoreboard_pkg::LAT_W,
    parameter int SCNT_W   = 32
);
    logic                id_valid_i;
    logic [REG_AW-1:0]   id_rs_i;
    logic [REG_AW-1:0]   id_rt_i;
    logic                id_rs_used_i;
    logic                id_rt_used_i;
    logic                id_bj_i;
    logic                id_wreg_i;
    logic [REG_AW-1:0]   id_dst_i;
    logic [LAT_W-1:0]    id_lat_i;
    logic                ex_stall_i;
    logic                flush_i;
    logic                stall_o;
    logic                stall_bj_o;
    logic [NUM_REGS-1:0] pending_o;
    logic [SCNT_W-1:0]   stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, id_bj_i,
               id_wreg_i, id_dst_i, id_lat_i, ex_stall_i, flush_i,
        input  stall_o, stall_bj_o, pending_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i, id_bj_i,
               id_wreg_i, id_dst_i, id_lat_i, ex_stall_i, flush_i,
        output stall_o, stall_bj_o, pending_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sb_entry
// Brief    : One register's countdown: hold, flush-clear, load or decrement.
// Revision : 1.0  initial release
// ============================================================================
module hazard_sb_entry #(
    parameter int LAT_W      = 3,
    parameter int FLUSH_KEEP = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_hold,
    input  wire logic             i_flush,
    input  wire logic             i_load,
    input  wire logic [LAT_W-1:0] i_load_val,
    output logic      [LAT_W-1:0] o_cnt
);
    localparam logic [LAT_W-1:0] c_keep = LAT_W'(FLUSH_KEEP);
    localparam logic [LAT_W-1:0] c_one  = LAT_W'(1);

    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_hold) begin
            r_cnt <= r_cnt;
        end else if (i_flush) begin
            // Producers already past the commit point keep draining normally.
            if (r_cnt > c_keep) begin
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_one;
            end
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register countdown scoreboard driving the ID-stage interlock.
// Revision : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = hazard_scoreboard_pkg::REG_AW,
    parameter int NUM_REGS   = hazard_scoreboard_pkg::NUM_REGS,
    parameter int LAT_W      = hazard_scoreboard_pkg::LAT_W,
    parameter int MAX_LAT    = hazard_scoreboard_pkg::MAX_LAT,
    parameter int FLUSH_KEEP = 1,
    parameter int SCNT_W     = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hazard_scoreboard_if.slave  sb
);
    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] c_one     = LAT_W'(1);

    logic [LAT_W-1:0]    w_cnt [NUM_REGS];
    logic [LAT_W-1:0]    w_cnt_rs;
    logic [LAT_W-1:0]    w_cnt_rt;
    logic [LAT_W-1:0]    w_lat_sat;
    logic                w_lat_nz;
    src_haz_t            w_haz_rs;
    src_haz_t            w_haz_rt;
    logic                w_stall;
    logic                w_late_any;
    logic                w_issue;
    logic [NUM_REGS-1:0] w_pending;
    logic [SCNT_W-1:0]   r_stall_cnt;

    assign w_cnt[0] = '0;

    assign w_lat_sat = (sb.id_lat_i > c_max_lat) ? c_max_lat : sb.id_lat_i;
    assign w_lat_nz  = (sb.id_lat_i != '0);

    assign w_cnt_rs = w_cnt[sb.id_rs_i];
    assign w_cnt_rt = w_cnt[sb.id_rt_i];

    assign w_haz_rs = classify_src(sb.id_rs_used_i, sb.id_rs_i != '0,
                                   w_cnt_rs > c_one, w_cnt_rs != '0, sb.id_bj_i);
    assign w_haz_rt = classify_src(sb.id_rt_used_i, sb.id_rt_i != '0,
                                   w_cnt_rt > c_one, w_cnt_rt != '0, sb.id_bj_i);

    assign w_late_any = w_haz_rs.late || w_haz_rt.late;
    assign w_stall    = rst_n && sb.id_valid_i &&
                        (w_late_any || w_haz_rs.early || w_haz_rt.early);
    assign w_issue    = sb.id_valid_i && !w_stall && !sb.ex_stall_i && !sb.flush_i;

    assign sb.stall_o    = w_stall;
    assign sb.stall_bj_o = w_stall && !w_late_any;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            logic w_load;
            // A zero-latency producer records nothing, so the counter keeps draining.
            assign w_load = w_issue && sb.id_wreg_i && w_lat_nz &&
                            (sb.id_dst_i == REG_AW'(r));

            hazard_sb_entry #(
                .LAT_W      (LAT_W),
                .FLUSH_KEEP (FLUSH_KEEP)
            ) u_entry (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_hold     (sb.ex_stall_i),
                .i_flush    (sb.flush_i),
                .i_load     (w_load),
                .i_load_val (w_lat_sat),
                .o_cnt      (w_cnt[r])
            );
        end
    endgenerate

    always_comb begin
        w_pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_pending[r] = (w_cnt[r] != '0);
        end
    end

    assign sb.pending_o = w_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !sb.ex_stall_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
        end
    end

    assign sb.stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Scenario and randomized checks of hazard_scoreboard against a latency model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if sb_if ();

    hazard_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int     n_checks = 0;
    int     n_err    = 0;
    int     m_cnt [NUM_REGS];
    longint m_scnt;

    // Model: m_cnt[r] = cycles until register r is visible to ID.
    function automatic bit m_late(input int s, input bit used);
        return used && s != 0 && m_cnt[s] > 1;
    endfunction

    function automatic bit m_early(input int s, input bit used);
        return used && s != 0 && sb_if.id_bj_i && m_cnt[s] != 0;
    endfunction

    function automatic bit m_late_any();
        return m_late(int'(sb_if.id_rs_i), sb_if.id_rs_used_i) ||
               m_late(int'(sb_if.id_rt_i), sb_if.id_rt_used_i);
    endfunction

    function automatic bit m_stall();
        return rst_n && sb_if.id_valid_i && (m_late_any() ||
               m_early(int'(sb_if.id_rs_i), sb_if.id_rs_used_i) ||
               m_early(int'(sb_if.id_rt_i), sb_if.id_rt_used_i));
    endfunction

    function automatic bit m_stall_bj();
        return m_stall() && !m_late_any();
    endfunction

    function automatic logic [NUM_REGS-1:0] m_pending();
        logic [NUM_REGS-1:0] p;
        p = '0;
        for (int r = 0; r < NUM_REGS; r++) p[r] = (m_cnt[r] != 0);
        return p;
    endfunction

    task automatic drive(input bit valid, input int rs, input int rt, input bit rsu,
                         input bit rtu, input bit bj, input bit wreg, input int dst,
                         input int lat);
        sb_if.id_valid_i   = valid;
        sb_if.id_rs_i      = REG_AW'(rs);
        sb_if.id_rt_i      = REG_AW'(rt);
        sb_if.id_rs_used_i = rsu;
        sb_if.id_rt_used_i = rtu;
        sb_if.id_bj_i      = bj;
        sb_if.id_wreg_i    = wreg;
        sb_if.id_dst_i     = REG_AW'(dst);
        sb_if.id_lat_i     = LAT_W'(lat);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sb_if.ex_stall_i = 1'b0;
        sb_if.flush_i    = 1'b0;
    endtask

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        int nxt [NUM_REGS];
        bit st, issue;
        int lat, dst;
        st    = m_stall();
        issue = sb_if.id_valid_i && !st && !sb_if.ex_stall_i && !sb_if.flush_i;
        lat   = int'(sb_if.id_lat_i);
        dst   = int'(sb_if.id_dst_i);
        for (int r = 0; r < NUM_REGS; r++) begin
            nxt[r] = m_cnt[r];
            if (!rst_n) nxt[r] = 0;
            else if (sb_if.ex_stall_i) nxt[r] = m_cnt[r];
            else if (sb_if.flush_i) nxt[r] = (m_cnt[r] > 1) ? 0 : (m_cnt[r] > 0 ? m_cnt[r] - 1 : 0);
            else if (issue && sb_if.id_wreg_i && dst == r && r != 0 && lat != 0)
                nxt[r] = (lat > MAX_LAT) ? MAX_LAT : lat;
            else if (m_cnt[r] > 0) nxt[r] = m_cnt[r] - 1;
        end
        @(posedge clk);
        if (!rst_n) m_scnt = 0;
        else if (st && !sb_if.ex_stall_i && m_scnt < 64'hFFFF_FFFF) m_scnt = m_scnt + 1;
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = nxt[r];
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Counts consecutive stalled cycles of the instruction held in ID (bounded).
    task automatic count_stalls(output int n, output bit bj_any);
        n = 0;
        bj_any = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (!sb_if.stall_o) break;
            n++;
            if (sb_if.stall_bj_o) bj_any = 1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        drive(1, 3, 4, 1, 1, 1, 1, 3, 2);
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b0 || sb_if.stall_bj_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: stall=%0b bj=%0b required 0 0", sb_if.stall_o, sb_if.stall_bj_o);
        end
        tick();
        tick();
        n_checks++;
        if (sb_if.pending_o !== '0 || sb_if.stall_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_state: pending=%h cnt=%0d required 0 0", sb_if.pending_o, sb_if.stall_cnt_o);
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_load_use();
        int n;
        bit bj;
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 2, LAT_LOAD);
        tick();
        drive(1, 2, 4, 1, 1, 0, 1, 3, LAT_ALU);
        count_stalls(n, bj);
        tick();
        idle();
        n_checks++;
        if (n != 1 || bj !== 1'b0 || sb_if.stall_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL load_use: stalls=%0d bj=%0b cnt=%0d required 1 0 1", n, bj, sb_if.stall_cnt_o);
        end
    endtask

    task automatic test_branch();
        int n;
        bit bj;
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 5, LAT_ALU);
        tick();
        drive(1, 5, 0, 1, 1, 1, 0, 0, 0);
        count_stalls(n, bj);
        tick();
        n_checks++;
        if (n != 1 || bj !== 1'b1) begin
            n_err++;
            $display("FAIL alu_branch: stalls=%0d bj=%0b required 1 1", n, bj);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 5, LAT_LOAD);
        tick();
        drive(1, 5, 0, 1, 1, 1, 0, 0, 0);
        count_stalls(n, bj);
        tick();
        idle();
        n_checks++;
        if (n != 2) begin
            n_err++;
            $display("FAIL load_branch: stalls=%0d required 2", n);
        end
    endtask

    task automatic test_mul_exstall();
        int n;
        n = 0;
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 8, LAT_MUL);
        tick();
        drive(1, 8, 0, 1, 0, 0, 1, 9, LAT_ALU);
        for (int k = 0; k < 16; k++) begin
            sb_if.ex_stall_i = (k >= 2 && k <= 4);
            #1;
            if (!sb_if.stall_o) break;
            n++;
            if (k == 3) begin
                n_checks++;
                if (sb_if.pending_o[8] !== 1'b1 || sb_if.pending_o !== m_pending()) begin
                    n_err++;
                    $display("FAIL mul_hold_pending: pending=%h required %h", sb_if.pending_o, m_pending());
                end
            end
            tick();
        end
        tick();
        idle();
        n_checks++;
        if (n != 7 || sb_if.stall_cnt_o !== 32'd4) begin
            n_err++;
            $display("FAIL mul_exstall: stalls=%0d cnt=%0d required 7 4", n, sb_if.stall_cnt_o);
        end
    endtask

    task automatic test_waw();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 6, LAT_LOAD);
        tick();
        drive(1, 7, 0, 1, 0, 0, 1, 6, LAT_ALU);
        tick();
        drive(1, 6, 0, 1, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL waw_load: stall=%0b required 0", sb_if.stall_o);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 6, LAT_MUL);
        tick();
        drive(1, 7, 0, 1, 0, 0, 1, 6, LAT_ALU);
        tick();
        drive(1, 0, 6, 0, 1, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL waw_mul: stall=%0b required 0", sb_if.stall_o);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 9, LAT_MUL);
        tick();
        idle();
        sb_if.flush_i = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 1, 12, 3);
        tick();
        idle();
        #1;
        n_checks++;
        if (sb_if.pending_o[9] !== 1'b0 || sb_if.pending_o[12] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: p9=%0b p12=%0b required 0 0", sb_if.pending_o[9], sb_if.pending_o[12]);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 10, LAT_LOAD);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 11, 4);
        tick();
        idle();
        sb_if.flush_i = 1'b1;
        #1;
        n_checks++;
        if (sb_if.pending_o[10] !== 1'b1 || sb_if.pending_o[11] !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre: p10=%0b p11=%0b required 1 1", sb_if.pending_o[10], sb_if.pending_o[11]);
        end
        tick();
        sb_if.flush_i = 1'b0;
        #1;
        n_checks++;
        if (sb_if.pending_o !== '0 || sb_if.pending_o !== m_pending()) begin
            n_err++;
            $display("FAIL flush_keep: pending=%h required %h", sb_if.pending_o, m_pending());
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0, LAT_MUL);
        tick();
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0);
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b0 || sb_if.pending_o !== '0) begin
            n_err++;
            $display("FAIL zero_reg: stall=%0b pending=%h required 0 0", sb_if.stall_o, sb_if.pending_o);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 11, LAT_MUL);
        tick();
        drive(1, 1, 11, 1, 0, 1, 0, 0, 0);
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL unused_rt: stall=%0b required 0", sb_if.stall_o);
        end
        sb_if.id_rt_used_i = 1'b1;
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b1 || sb_if.stall_bj_o !== 1'b0) begin
            n_err++;
            $display("FAIL used_rt: stall=%0b bj=%0b required 1 0", sb_if.stall_o, sb_if.stall_bj_o);
        end
        idle();
    endtask

    task automatic test_reset_midstall();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 12, LAT_MUL);
        tick();
        drive(1, 12, 0, 1, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sb_if.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_comb: stall=%0b required 0", sb_if.stall_o);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (sb_if.pending_o !== '0 || sb_if.stall_cnt_o !== '0 || sb_if.stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: pending=%h cnt=%0d stall=%0b required 0 0 0",
                     sb_if.pending_o, sb_if.stall_cnt_o, sb_if.stall_o);
        end
        idle();
    endtask

    task automatic test_random();
        bit es;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            es = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
            sb_if.ex_stall_i = es;
            sb_if.flush_i    = !es && ($urandom_range(0, 15) == 0);
            #1;
            n_checks++;
            if (sb_if.stall_o !== m_stall() || sb_if.stall_bj_o !== m_stall_bj() ||
                sb_if.pending_o !== m_pending() || sb_if.stall_cnt_o !== 32'(m_scnt)) begin
                n_err++;
                $display("FAIL random[%0d]: stall=%0b bj=%0b pend=%h cnt=%0d required %0b %0b %h %0d",
                         c, sb_if.stall_o, sb_if.stall_bj_o, sb_if.pending_o, sb_if.stall_cnt_o,
                         m_stall(), m_stall_bj(), m_pending(), m_scnt);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
        m_scnt = 0;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mul_exstall();
        test_waw();
        test_flush();
        test_zero_reg();
        test_reset_midstall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
